koa_multiplier_core: RTL and testbench

KOA_MULTIPLIER_CORE -- requirements
Module: koa_multiplier

---
 rtl/koa_multiplier_core.sv | 149 ++++++++++++++
 tb/tb_koa_multiplier_core.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/koa_multiplier_core.sv
// Pipelined recursive Karatsuba-Ofman unsigned multiplier (DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH).
// Optional macro KOA_INPUT_REG_EN adds an input register stage (latency 2 instead of 1).

module koa_node #(
  parameter int unsigned W    = 16,
  parameter int unsigned LEAF = 16
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  generate
    // Widths below 4 go direct: the h+1 middle product would not be narrower than W.
    if ((W <= LEAF) || (W < 4)) begin : g_leaf
      logic [2*W-1:0] ax;
      logic [2*W-1:0] bx;
      assign ax  = {{W{1'b0}}, a_i};
      assign bx  = {{W{1'b0}}, b_i};
      assign p_o = ax * bx;
    end else begin : g_split
      localparam int unsigned H  = (W + 1) / 2;
      localparam int unsigned HW = W - H;

      logic [H-1:0]     al;
      logic [H-1:0]     bl;
      logic [HW-1:0]    ah;
      logic [HW-1:0]    bh;
      logic [H:0]       sa;
      logic [H:0]       sb;
      logic [2*HW-1:0]  z2;
      logic [2*H-1:0]   z0;
      logic [2*H+1:0]   zm;
      logic [2*H+1:0]   z1;
      logic [2*W-1:0]   z2x;
      logic [2*W-1:0]   z1x;
      logic [2*W-1:0]   z0x;

      assign al = a_i[H-1:0];
      assign bl = b_i[H-1:0];
      assign ah = a_i[W-1:H];
      assign bh = b_i[W-1:H];

      assign sa = {1'b0, al} + {{(2*H+1-W){1'b0}}, ah};
      assign sb = {1'b0, bl} + {{(2*H+1-W){1'b0}}, bh};

      koa_node #(.W(HW), .LEAF(LEAF)) u_z2 (
        .a_i (ah),
        .b_i (bh),
        .p_o (z2)
      );

      koa_node #(.W(H), .LEAF(LEAF)) u_z0 (
        .a_i (al),
        .b_i (bl),
        .p_o (z0)
      );

      koa_node #(.W(H + 1), .LEAF(LEAF)) u_zm (
        .a_i (sa),
        .b_i (sb),
        .p_o (zm)
      );

      // zm >= z2 + z0 always, so z1 fits unsigned in 2h+2 bits.
      assign z1  = zm - {{(4*H+2-2*W){1'b0}}, z2} - {2'b00, z0};

      assign z2x = {z2, {(2*H){1'b0}}};
      assign z0x = {{(2*HW){1'b0}}, z0};
      assign z1x = {{(2*W-2*H-2){1'b0}}, z1} << H;
      assign p_o = z2x + z1x + z0x;
    end
  endgenerate

endmodule

module koa_multiplier_core #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned LEAF_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   mult_a,
  input  logic [DATA_WIDTH-1:0]   mult_b,
  output logic                    out_valid,
  output logic [2*DATA_WIDTH-1:0] mult_d
);

  logic [DATA_WIDTH-1:0]   op_a;
  logic [DATA_WIDTH-1:0]   op_b;
  logic                    op_v;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [2*DATA_WIDTH-1:0] prod_d;
  logic [2*DATA_WIDTH-1:0] prod_q;
  logic                    vld_q;

`ifdef KOA_INPUT_REG_EN
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  v_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
    end else begin
      a_q <= mult_a;
      b_q <= mult_b;
      v_q <= in_valid;
    end
  end

  assign op_a = a_q;
  assign op_b = b_q;
  assign op_v = v_q;
`else
  assign op_a = mult_a;
  assign op_b = mult_b;
  assign op_v = in_valid;
`endif

  koa_node #(.W(DATA_WIDTH), .LEAF(LEAF_WIDTH)) u_core (
    .a_i (op_a),
    .b_i (op_b),
    .p_o (prod)
  );

  // The product register only loads on a valid pair so mult_d holds across gaps.
  always_comb begin
    prod_d = prod_q;
    if (op_v) prod_d = prod;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      vld_q  <= op_v;
    end
  end

  assign mult_d    = prod_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_koa_multiplier_core.sv
// Directed self-checking bench for koa_multiplier_core; latency follows KOA_INPUT_REG_EN.

module tb_koa_multiplier_core;

  localparam int unsigned DW = 128;
`ifdef KOA_INPUT_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [DW-1:0]   mult_a;
  logic [DW-1:0]   mult_b;
  logic            out_valid;
  logic [2*DW-1:0] mult_d;

  int checks   = 0;
  int failures = 0;

  logic            exp_v;
  logic [2*DW-1:0] exp_d;
  logic            s_v;
  logic [2*DW-1:0] s_d;
  logic [DW-1:0]   ones;

  always #5 clk = ~clk;

  koa_multiplier_core #(.DATA_WIDTH(DW), .LEAF_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .out_valid (out_valid),
    .mult_d    (mult_d)
  );

  function automatic logic [2*DW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] ax;
    logic [2*DW-1:0] bx;
    ax = {{DW{1'b0}}, a};
    bx = {{DW{1'b0}}, b};
    return ax * bx;
  endfunction

  task automatic check_out(input string tag);
    checks++;
    assert (out_valid === exp_v) else begin
      failures++;
      $error("FAIL %s out_valid observed=%b expected=%b", tag, out_valid, exp_v);
    end
    checks++;
    assert (mult_d === exp_d) else begin
      failures++;
      $error("FAIL %s mult_d observed=%h expected=%h", tag, mult_d, exp_d);
    end
  endtask

  task automatic check_const(input string tag, input logic [2*DW-1:0] req);
    checks++;
    assert (mult_d === req) else begin
      failures++;
      $error("FAIL %s mult_d observed=%h expected=%h", tag, mult_d, req);
    end
  endtask

  // Called at a falling edge: drive, advance the reference pipeline at the rising edge, check at the next falling edge.
  task automatic tick(input string tag, input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic            nv;
    logic [2*DW-1:0] nd;
    in_valid = v;
    mult_a   = a;
    mult_b   = b;
    @(posedge clk);
    if (rst) begin
      s_v   = 1'b0;
      s_d   = '0;
      exp_v = 1'b0;
      exp_d = '0;
    end else begin
      if (LAT == 2) begin
        nv  = s_v;
        nd  = s_d;
        s_v = v;
        s_d = ref_mul(a, b);
      end else begin
        nv = v;
        nd = ref_mul(a, b);
      end
      exp_v = nv;
      if (nv) exp_d = nd;
    end
    @(negedge clk);
    check_out(tag);
  endtask

  task automatic flush(input string tag);
    for (int unsigned i = 0; i < LAT; i++)
      tick(tag, 1'b0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
  endtask

  initial begin
    ones     = '1;
    rst      = 1'b1;
    in_valid = 1'b0;
    mult_a   = '0;
    mult_b   = '0;
    exp_v    = 1'b0;
    exp_d    = '0;
    s_v      = 1'b0;
    s_d      = '0;

    #1 check_out("reset_async");
    @(negedge clk);
    tick("reset_hold0", 1'b1, ones, ones);
    tick("reset_hold1", 1'b1, 128'd5, 128'd7);
    rst = 1'b0;

    tick("zero_x_zero", 1'b1, '0, '0);
    flush("zero_flush");
    check_const("zero_const", '0);

    tick("all_ones", 1'b1, ones, ones);
    flush("all_ones_flush");
    check_const("all_ones_const", {128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 128'h1});

    tick("b2b_0", 1'b1, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA, 128'h55555555_55555555_55555555_55555555);
    tick("b2b_1", 1'b1, 128'hDEADBEEF_CAFEBABE_12345678_9ABCDEF0, 128'h01234567_89ABCDEF_DEADBEEF_CAFEBABE);
    tick("b2b_2", 1'b1, 128'h11111111_11111111_11111111_11111111, 128'h22222222_22222222_22222222_22222222);
    tick("b2b_3", 1'b1, 128'hFEDCBA98_76543210_01234567_89ABCDEF, 128'hABCDEF01_23456789_FEDCBA98_76543210);
    flush("b2b_flush");

    tick("toggle_1a", 1'b1, 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFF, 128'h8000_0000_0000_0000_0000_0000_0000_0003);
    tick("toggle_0",  1'b0, 128'h12345, 128'h6789A);
    tick("toggle_1b", 1'b1, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 128'h0000_FFFF_0000_FFFF_0000_FFFF_0000_FFFF);
    flush("toggle_flush");

    tick("msb_sq", 1'b1, {1'b1, 127'b0}, {1'b1, 127'b0});
    flush("msb_flush");
    check_const("msb_const", {2'b01, 254'b0});

    tick("one_x_ones", 1'b1, 128'h1, ones);
    tick("ones_x_zero", 1'b1, ones, '0);
    tick("leaf_edge", 1'b1, 128'h1_0000_FFFF, 128'h1_FFFF_0001);
    flush("misc_flush");

    tick("inflight_prev", 1'b1, 128'hCAFE, 128'hBEEF);
    in_valid = 1'b1;
    mult_a   = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    mult_b   = 128'h13579BDF_2468ACE0_13579BDF_2468ACE0;
    #2 rst   = 1'b1;
    s_v   = 1'b0;
    s_d   = '0;
    exp_v = 1'b0;
    exp_d = '0;
    #1 check_out("rst_mid_cycle");
    @(negedge clk);
    tick("rst_hold", 1'b1, ones, 128'h3);
    rst = 1'b0;
    tick("post_rst_idle0", 1'b0, '0, '0);
    tick("post_rst_idle1", 1'b0, '0, '0);
    tick("post_rst_first", 1'b1, 128'hFFFF_FFFF, 128'hFFFF_FFFF);
    flush("post_rst_flush");
    check_const("post_rst_const", 256'hFFFF_FFFE_0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
